// File: rtl/txn_pkg.sv
// Shared definitions for the balance-transfer controller: widths, player
// addresses, direction key codes and the FSM state encoding.
package txn_pkg;

    localparam int         BAL_W        = 8;
    localparam logic       ADDR_P1      = 1'b0;
    localparam logic       ADDR_P2      = 1'b1;
    localparam logic [1:0] KEY_P1_TO_P2 = 2'b01;
    localparam logic [1:0] KEY_P2_TO_P1 = 2'b10;

    typedef enum logic [3:0] {
        IDLE,
        RD_SRC,
        RD_DST,
        CHECK,
        WR_SRC,
        WR_DST,
        ANIM,
        DONE,
        WAIT_LOW
    } state_t;

    function automatic logic key_valid(input logic [1:0] key);
        return (key == KEY_P1_TO_P2) || (key == KEY_P2_TO_P1);
    endfunction

endpackage

// File: rtl/txn_operand_check.sv
// Holds the transfer operands (amount, key, both balances) and produces the
// accept/reject decision plus the two post-transfer balances.
module txn_operand_check
    import txn_pkg::*;
(
    input  logic             clk,
    input  logic             srst,
    input  logic             capture_en_i,
    input  logic             load_amount_i,
    input  logic             load_key_i,
    input  logic [BAL_W-1:0] amount_i,
    input  logic [1:0]       key_i,
    input  logic             src_cap_i,
    input  logic             dst_cap_i,
    input  logic [BAL_W-1:0] mem_rdata_i,
    output logic             src_addr_o,
    output logic             dst_addr_o,
    output logic             reject_o,
    output logic [BAL_W-1:0] src_new_o,
    output logic [BAL_W-1:0] dst_new_o
);

    logic [BAL_W-1:0] amount_q, amount_d;
    logic [1:0]       key_q, key_d;
    logic [BAL_W-1:0] src_bal_q, src_bal_d;
    logic [BAL_W-1:0] dst_bal_q, dst_bal_d;
    logic [BAL_W:0]   dst_sum;

    always_comb begin
        amount_d  = amount_q;
        key_d     = key_q;
        src_bal_d = src_bal_q;
        dst_bal_d = dst_bal_q;
        if (capture_en_i && load_amount_i) amount_d = amount_i;
        if (capture_en_i && load_key_i)    key_d    = key_i;
        if (src_cap_i)                     src_bal_d = mem_rdata_i;
        if (dst_cap_i)                     dst_bal_d = mem_rdata_i;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            amount_q  <= '0;
            key_q     <= '0;
            src_bal_q <= '0;
            dst_bal_q <= '0;
        end else begin
            amount_q  <= amount_d;
            key_q     <= key_d;
            src_bal_q <= src_bal_d;
            dst_bal_q <= dst_bal_d;
        end
    end

    assign src_addr_o = (key_q == KEY_P2_TO_P1) ? ADDR_P2 : ADDR_P1;
    assign dst_addr_o = (key_q == KEY_P2_TO_P1) ? ADDR_P1 : ADDR_P2;

    // The destination balance arrives on the read bus during the check cycle
    // itself, so the overflow test uses it live instead of the captured copy.
    assign dst_sum  = {1'b0, mem_rdata_i} + {1'b0, amount_q};
    assign reject_o = !key_valid(key_q) || (src_bal_q < amount_q) || dst_sum[BAL_W];

    assign src_new_o = src_bal_q - amount_q;
    assign dst_new_o = dst_bal_q + amount_q;

endmodule

// File: rtl/transaction_control.sv
// Transfer FSM: reads both balances, checks the request, writes the new
// balances, runs the animation and hands back a one-cycle completion pulse.
module transaction_control
    import txn_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load_amount,
    input  logic             load_key,
    input  logic [BAL_W-1:0] amount_in,
    input  logic [1:0]       key_in,
    input  logic             start_transaction,
    input  logic [BAL_W-1:0] mem_rdata,
    input  logic             anim_done,
    output logic             mem_addr,
    output logic [BAL_W-1:0] mem_wdata,
    output logic             mem_we,
    output logic             anim_start,
    output logic             finished_transaction,
    output logic             txn_ok,
    output logic             txn_rejected
);

    state_t           state_q, state_d;
    logic             txn_ok_q, txn_ok_d;
    logic             txn_rej_q, txn_rej_d;
    logic             anim_start_q, anim_start_d;
    logic             src_addr, dst_addr, reject;
    logic [BAL_W-1:0] src_new, dst_new;

    txn_operand_check u_check (
        .clk           (clock),
        .srst          (reset),
        .capture_en_i  (state_q == IDLE),
        .load_amount_i (load_amount),
        .load_key_i    (load_key),
        .amount_i      (amount_in),
        .key_i         (key_in),
        .src_cap_i     (state_q == RD_DST),
        .dst_cap_i     (state_q == CHECK),
        .mem_rdata_i   (mem_rdata),
        .src_addr_o    (src_addr),
        .dst_addr_o    (dst_addr),
        .reject_o      (reject),
        .src_new_o     (src_new),
        .dst_new_o     (dst_new)
    );

    always_comb begin
        state_d              = state_q;
        txn_ok_d             = txn_ok_q;
        txn_rej_d            = txn_rej_q;
        anim_start_d         = 1'b0;
        mem_addr             = ADDR_P1;
        mem_wdata            = '0;
        mem_we               = 1'b0;
        finished_transaction = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_transaction) begin
                    state_d   = RD_SRC;
                    txn_ok_d  = 1'b0;
                    txn_rej_d = 1'b0;
                end
            end
            RD_SRC: begin
                mem_addr = src_addr;
                state_d  = RD_DST;
            end
            RD_DST: begin
                mem_addr = dst_addr;
                state_d  = CHECK;
            end
            CHECK: begin
                if (reject) begin
                    txn_rej_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    state_d   = WR_SRC;
                end
            end
            WR_SRC: begin
                mem_addr  = src_addr;
                mem_wdata = src_new;
                mem_we    = 1'b1;
                state_d   = WR_DST;
            end
            WR_DST: begin
                mem_addr     = dst_addr;
                mem_wdata    = dst_new;
                mem_we       = 1'b1;
                txn_ok_d     = 1'b1;
                anim_start_d = 1'b1;
                state_d      = ANIM;
            end
            ANIM: begin
                if (anim_done) state_d = DONE;
            end
            DONE: begin
                finished_transaction = 1'b1;
                state_d              = WAIT_LOW;
            end
            WAIT_LOW: begin
                // Level request: wait for release so one request is one transfer.
                if (!start_transaction) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            txn_ok_q     <= 1'b0;
            txn_rej_q    <= 1'b0;
            anim_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            txn_ok_q     <= txn_ok_d;
            txn_rej_q    <= txn_rej_d;
            anim_start_q <= anim_start_d;
        end
    end

    assign anim_start   = anim_start_q;
    assign txn_ok       = txn_ok_q;
    assign txn_rejected = txn_rej_q;

endmodule

// File: tb/tb_transaction_control.sv
// Directed bench for transaction_control with a two-entry balance memory
// and a fixed-delay animation responder.
module tb_transaction_control;

    logic       clock;
    logic       reset;
    logic       load_amount;
    logic       load_key;
    logic [7:0] amount_in;
    logic [1:0] key_in;
    logic       start_transaction;
    logic [7:0] mem_rdata;
    logic       anim_done;
    logic       mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic       anim_start;
    logic       finished_transaction;
    logic       txn_ok;
    logic       txn_rejected;

    transaction_control dut (
        .clock                (clock),
        .reset                (reset),
        .load_amount          (load_amount),
        .load_key             (load_key),
        .amount_in            (amount_in),
        .key_in               (key_in),
        .start_transaction    (start_transaction),
        .mem_rdata            (mem_rdata),
        .anim_done            (anim_done),
        .mem_addr             (mem_addr),
        .mem_wdata            (mem_wdata),
        .mem_we               (mem_we),
        .anim_start           (anim_start),
        .finished_transaction (finished_transaction),
        .txn_ok               (txn_ok),
        .txn_rejected         (txn_rejected)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Balance memory: registered read, data valid one cycle after the address.
    logic [7:0] mem [0:1];
    logic       pre_en;
    logic [7:0] pre_p1, pre_p2;

    always @(posedge clock) begin
        if (pre_en) begin
            mem[0] <= pre_p1;
            mem[1] <= pre_p2;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    // Animation responder: anim_done four edges after anim_start is seen.
    logic       anim_auto_en;
    logic       anim_manual;
    logic [3:0] anim_sr;

    always @(posedge clock) anim_sr <= {anim_sr[2:0], anim_start & anim_auto_en};
    assign anim_done = anim_sr[3] | anim_manual;

    // Event monitor, sampled on the falling edge.
    int         log_n    = 0;
    int         fin_cnt  = 0;
    int         anst_cnt = 0;
    logic [8:0] log_w [0:31];

    always @(negedge clock) begin
        if (mem_we && log_n < 32) begin
            log_w[log_n] = {mem_addr, mem_wdata};
            log_n++;
        end
        if (finished_transaction) fin_cnt++;
        if (anim_start) anst_cnt++;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [7:0] p1, input logic [7:0] p2);
        @(negedge clock);
        pre_p1 = p1;
        pre_p2 = p2;
        pre_en = 1'b1;
        @(negedge clock);
        pre_en = 1'b0;
    endtask

    task automatic load_ops(input logic [7:0] amt, input logic [1:0] key);
        @(negedge clock);
        amount_in   = amt;
        key_in      = key;
        load_amount = 1'b1;
        load_key    = 1'b1;
        @(negedge clock);
        load_amount = 1'b0;
        load_key    = 1'b0;
        amount_in   = 8'd0;
        key_in      = 2'b00;
    endtask

    // Runs one request; 'glitch' drives load strobes with amount 99 while in RD_DST.
    task automatic run_txn(input logic [7:0] amt, input logic [1:0] key, input int hold,
                           input bit glitch, output int lat, output int we0,
                           output int an0, output int fin0);
        int n;
        load_ops(amt, key);
        we0  = log_n;
        an0  = anst_cnt;
        fin0 = fin_cnt;
        start_transaction = 1'b1;
        n = 0;
        while (finished_transaction !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
            if (glitch && n == 2) begin
                amount_in   = 8'd99;
                key_in      = 2'b10;
                load_amount = 1'b1;
                load_key    = 1'b1;
            end else begin
                load_amount = 1'b0;
                load_key    = 1'b0;
            end
        end
        lat = n;
        chk("finish_seen", {31'd0, finished_transaction}, 32'd1);
        repeat (hold) @(negedge clock);
        start_transaction = 1'b0;
        repeat (2) @(negedge clock);
        $display("txn amt=%0d key=%b lat=%0d ok=%b rej=%b writes=%0d",
                 amt, key, lat, txn_ok, txn_rejected, log_n - we0);
    endtask

    task automatic check_txn(input string tag, input int lat, input int exp_lat,
                             input logic exp_ok, input int we0, input int an0,
                             input int fin0, input logic [8:0] w0, input logic [8:0] w1);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_txn_ok"}, {31'd0, txn_ok}, {31'd0, exp_ok});
        chk({tag, "_txn_rejected"}, {31'd0, txn_rejected}, {31'd0, ~exp_ok});
        chk({tag, "_writes"}, log_n - we0, exp_ok ? 32'd2 : 32'd0);
        chk({tag, "_anim_starts"}, anst_cnt - an0, exp_ok ? 32'd1 : 32'd0);
        chk({tag, "_finished_pulses"}, fin_cnt - fin0, 32'd1);
        if (exp_ok) begin
            chk({tag, "_write0"}, {23'd0, log_w[we0]}, {23'd0, w0});
            chk({tag, "_write1"}, {23'd0, log_w[we0 + 1]}, {23'd0, w1});
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_mem_addr"}, {31'd0, mem_addr}, 32'd0);
        chk({tag, "_mem_wdata"}, {24'd0, mem_wdata}, 32'd0);
        chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        chk({tag, "_anim_start"}, {31'd0, anim_start}, 32'd0);
        chk({tag, "_finished"}, {31'd0, finished_transaction}, 32'd0);
        chk({tag, "_txn_ok"}, {31'd0, txn_ok}, 32'd0);
        chk({tag, "_txn_rejected"}, {31'd0, txn_rejected}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, we0, an0, fin0, n;
        reset = 1'b1;
        load_amount = 1'b0;
        load_key = 1'b0;
        amount_in = 8'd0;
        key_in = 2'b00;
        start_transaction = 1'b0;
        anim_manual = 1'b0;
        anim_auto_en = 1'b1;
        anim_sr = 4'd0;
        pre_en = 1'b0;
        pre_p1 = 8'd0;
        pre_p2 = 8'd0;
        mem[0] = 8'd0;
        mem[1] = 8'd0;
        mem_rdata = 8'd0;
        repeat (3) @(negedge clock);
        chk_outputs_zero("reset");
        reset = 1'b0;
        @(negedge clock);

        // P1=100, P2=50, move 30 P1->P2; start held 20 cycles past finish.
        // Accepted latency: 7 plus 4 extra ANIM cycles from the responder.
        preload(8'd100, 8'd50);
        run_txn(8'd30, 2'b01, 20, 1'b0, lat, we0, an0, fin0);
        check_txn("t1", lat, 11, 1'b1, we0, an0, fin0, {1'b0, 8'd70}, {1'b1, 8'd80});
        chk("t1_mem_p1", {24'd0, mem[0]}, 32'd70);
        chk("t1_mem_p2", {24'd0, mem[1]}, 32'd80);

        // Insufficient funds: P1=20, amount 21.
        preload(8'd20, 8'd50);
        run_txn(8'd21, 2'b01, 0, 1'b0, lat, we0, an0, fin0);
        check_txn("t2", lat, 4, 1'b0, we0, an0, fin0, 9'd0, 9'd0);
        chk("t2_mem_p1", {24'd0, mem[0]}, 32'd20);

        // P2->P1 with P1=250: 250+10 overflows, then 250+5 = 255 fits.
        preload(8'd250, 8'd10);
        run_txn(8'd10, 2'b10, 0, 1'b0, lat, we0, an0, fin0);
        check_txn("t3a", lat, 4, 1'b0, we0, an0, fin0, 9'd0, 9'd0);
        run_txn(8'd5, 2'b10, 0, 1'b0, lat, we0, an0, fin0);
        check_txn("t3b", lat, 11, 1'b1, we0, an0, fin0, {1'b1, 8'd5}, {1'b0, 8'd255});
        chk("t3b_mem_p1", {24'd0, mem[0]}, 32'd255);
        chk("t3b_mem_p2", {24'd0, mem[1]}, 32'd5);

        // Zero amount still writes both balances back unchanged.
        run_txn(8'd0, 2'b01, 0, 1'b0, lat, we0, an0, fin0);
        check_txn("t4", lat, 11, 1'b1, we0, an0, fin0, {1'b0, 8'd255}, {1'b1, 8'd5});

        // Invalid key with start held high for 20 cycles after finish.
        run_txn(8'd1, 2'b11, 20, 1'b0, lat, we0, an0, fin0);
        check_txn("t5", lat, 4, 1'b0, we0, an0, fin0, 9'd0, 9'd0);

        // Load strobes with amount 99 in mid-transaction must be ignored.
        preload(8'd100, 8'd50);
        run_txn(8'd30, 2'b01, 0, 1'b1, lat, we0, an0, fin0);
        check_txn("t6", lat, 11, 1'b1, we0, an0, fin0, {1'b0, 8'd70}, {1'b1, 8'd80});

        // Source balance equal to amount is allowed: P2=40 -> 0, P1=40 -> 80.
        preload(8'd40, 8'd40);
        run_txn(8'd40, 2'b10, 0, 1'b0, lat, we0, an0, fin0);
        check_txn("t7", lat, 11, 1'b1, we0, an0, fin0, {1'b1, 8'd0}, {1'b0, 8'd80});

        // Reset during ANIM, then a stray anim_done.
        anim_auto_en = 1'b0;
        preload(8'd100, 8'd50);
        load_ops(8'd30, 2'b01);
        an0  = anst_cnt;
        fin0 = fin_cnt;
        start_transaction = 1'b1;
        n = 0;
        while (anim_start !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("t8_anim_start_seen", {31'd0, anim_start}, 32'd1);
        chk("t8_txn_ok_in_anim", {31'd0, txn_ok}, 32'd1);
        reset = 1'b1;
        start_transaction = 1'b0;
        @(negedge clock);
        chk_outputs_zero("t8_reset");
        reset = 1'b0;
        @(negedge clock);
        anim_manual = 1'b1;
        @(negedge clock);
        anim_manual = 1'b0;
        repeat (4) @(negedge clock);
        chk("t8_no_finish", fin_cnt - fin0, 32'd0);
        chk("t8_anim_starts", anst_cnt - an0, 32'd1);
        chk("t8_txn_ok_after", {31'd0, txn_ok}, 32'd0);
        chk("t8_mem_p1", {24'd0, mem[0]}, 32'd70);
        chk("t8_mem_p2", {24'd0, mem[1]}, 32'd80);
        $display("txn amt=30 key=01 reset during ANIM, finishes=%0d", fin_cnt - fin0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/transaction_control.md
TRANSACTION_CONTROL -- requirements
Module: transaction_control

Interface
REQ-001 SHALL have one clock and one reset: the reset is synchronous and active-high.
REQ-002 SHALL declare port clock, input, 1 bit: system clock; all state updates on its rising edge.
REQ-003 SHALL declare port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL declare port load_amount, input, 1 bit: while high, captures amount_in each cycle.
REQ-005 SHALL declare port load_key, input, 1 bit: while high, captures key_in each cycle.
REQ-006 SHALL declare port amount_in, input, 8 bits: unsigned transfer amount from switches.
REQ-007 SHALL declare port key_in, input, 2 bits: direction; 2'b01 moves P1 to P2, 2'b10 moves P2 to P1, other values are invalid.
REQ-008 SHALL declare port start_transaction, input, 1 bit: level request, held high until after finished_transaction.
REQ-009 SHALL declare port mem_rdata, input, 8 bits: balance read data, valid 1 cycle after mem_addr is presented.
REQ-010 SHALL declare port anim_done, input, 1 bit: animation block completion pulse.
REQ-011 SHALL declare port mem_addr, output, 1 bit: 0 selects P1 and 1 selects P2.
REQ-012 SHALL declare port mem_wdata, output, 8 bits: balance to write.
REQ-013 SHALL declare port mem_we, output, 1 bit: write strobe, one cycle per write.
REQ-014 SHALL declare port anim_start, output, 1 bit: one-cycle pulse that launches the animation.
REQ-015 SHALL declare port finished_transaction, output, 1 bit: one-cycle completion pulse to the main controller.
REQ-016 SHALL declare port txn_ok, output, 1 bit: last transaction committed; held until the next start.
REQ-017 SHALL declare port txn_rejected, output, 1 bit: last transaction refused; held until the next start.

Function
REQ-018 SHALL latch amount and key into internal registers only while in IDLE, and ignore load strobes in every other state.
REQ-019 SHALL use FSM states IDLE, RD_SRC, RD_DST, CHECK, WR_SRC, WR_DST, ANIM, DONE, WAIT_LOW.
REQ-020 SHALL move IDLE to RD_SRC on start_transaction=1, clearing txn_ok and txn_rejected.
REQ-021 SHALL, in RD_SRC, drive mem_addr=source and capture mem_rdata as src_bal one cycle later; RD_DST does the same for the destination as dst_bal.
REQ-022 SHALL, in CHECK, reject if the key is invalid, if src_bal < amount, or if the 9-bit sum dst_bal+amount exceeds 255; the check is a single cycle.
REQ-023 SHALL, on reject, set txn_rejected=1 and go to DONE with no memory write and no animation.
REQ-024 SHALL, on accept, write src_bal-amount in WR_SRC, then dst_bal+amount in WR_DST, one cycle each with mem_we=1, then set txn_ok=1.
REQ-025 SHALL pulse anim_start for the first cycle of ANIM and remain in ANIM until anim_done=1.
REQ-026 SHALL pulse finished_transaction for exactly one cycle in DONE, then go to WAIT_LOW.
REQ-027 SHALL hold WAIT_LOW until start_transaction=0, then return to IDLE, so one request yields exactly one transaction.
REQ-028 SHALL treat amount=0 as valid: both writes occur with unchanged values.
REQ-029 SHALL have an accepted-transaction latency of 7 cycles plus the animation time from the start edge to finished_transaction.
REQ-030 SHALL ignore anim_done outside ANIM.

Reset
REQ-031 SHALL, on reset=1 at a clock edge, enter IDLE, clear the amount/key registers, src_bal and dst_bal, and drive all outputs to 0.
REQ-032 SHALL let reset take priority in every state; a reset between WR_SRC and WR_DST leaves only the source write done, which is accepted behaviour.

Structure
REQ-033 SHALL place the state encoding, BAL_W=8, ADDR_P1=1'b0, ADDR_P2=1'b1 and the key codes in shared package txn_pkg.
REQ-034 SHALL implement operand capture and the validity/funds/overflow checks in sub-module txn_operand_check, with the FSM kept in transaction_control.

Verification
REQ-035 SHALL cover: P1=100, P2=50, amount=30, key=01 -> writes P1=70 then P2=80, txn_ok=1, one finished_transaction pulse.
REQ-036 SHALL cover: P1=20, amount=21, key=01 -> txn_rejected=1, mem_we never high, anim_start never high.
REQ-037 SHALL cover: P2=10, P1=250, amount=10, key=10 -> rejected on overflow; amount=5 -> P2=5 and P1=255 accepted.
REQ-038 SHALL cover: key=11 -> rejected; start held high 20 cycles after finish -> no second transaction.
REQ-039 SHALL cover: reset asserted during ANIM -> next cycle IDLE with all outputs 0; a later anim_done pulse is ignored.
REQ-040 SHALL cover: load_amount pulsed mid-transaction with amount_in=99 -> the latched amount is unchanged.
